// File: rtl/turf_bank_pkg.sv
// turf_bank_pkg: shared types and widths for the TURF bank read-port arbiter.
// Holds the arbiter FSM encoding and bank address/data widths.
package turf_bank_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/turf_bank_if.sv
// turf_bank_if: bank read-port signals shared by the TURFIO bus,
// the internal requesters and the bank mux.
interface turf_bank_if #(
    parameter int NREQ = 2
);
    import turf_bank_pkg::*;

    logic                     bus_req_i;
    logic [ADDR_W-1:0]        bus_addr_i;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [DATA_W-1:0]        mem_dat_i;
    logic [DATA_W-1:0]        bus_dat_o;
    logic [NREQ-1:0]          int_req_i;
    logic [ADDR_W*NREQ-1:0]   int_addr_i;
    logic [NREQ-1:0]          int_ack_o;
    logic [DATA_W-1:0]        int_dat_o;
    logic                     busy_o;

    modport slave (
        input  bus_req_i, bus_addr_i, mem_dat_i, int_req_i, int_addr_i,
        output mem_addr_o, bus_dat_o, int_ack_o, int_dat_o, busy_o
    );

    modport master (
        output bus_req_i, bus_addr_i, mem_dat_i, int_req_i, int_addr_i,
        input  mem_addr_o, bus_dat_o, int_ack_o, int_dat_o, busy_o
    );

endinterface

// File: rtl/turf_rr_select.sv
// turf_rr_select: combinational round-robin picker, returns the first
// asserted request at or after ptr (wrapping) plus a valid flag.
module turf_rr_select #(
    parameter int  NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Scan farthest offset first so the nearest request wins last.
    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/turf_bank_arbiter.sv
// turf_bank_arbiter: shares the bank read port between the TURFIO bus
// (absolute priority) and NREQ round-robin internal requesters.
// Optional stall statistics when TURF_BANK_ARB_STATS_EN is defined.
module turf_bank_arbiter
    import turf_bank_pkg::*;
#(
    parameter int  NREQ     = 2,
    parameter int  RD_LAT   = 1,
    parameter int  BUS_HOLD = 4,
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int HW       = (BUS_HOLD > 1) ? $clog2(BUS_HOLD + 1) : 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef TURF_BANK_ARB_STATS_EN
    input  logic        stats_clr_i,
    output logic [15:0] stall_cnt_o,
`endif
    turf_bank_if.slave  bus
);

    state_t            state, state_nxt;
    logic [IW-1:0]     grant, ptr, sel_idx;
    logic              sel_valid;
    logic [ADDR_W-1:0] addr_q, bus_addr_q, mem_addr;
    logic [HW-1:0]     hold;
    logic [1:0]        lat;
    logic              stall, issue, capture;
    logic [NREQ-1:0]   ack;

    turf_rr_select #(.NREQ(NREQ)) u_sel (
        .req   (bus.int_req_i),
        .ptr   (ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    assign stall   = bus.bus_req_i || (hold != '0);
    assign issue   = (state == S_ISSUE) && !stall;
    assign capture = (issue && (RD_LAT == 0)) ||
                     ((state == S_WAIT) && (lat == 2'd1));

    // Next-state decode for the internal transaction FSM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (sel_valid) state_nxt = S_ISSUE;
            S_ISSUE: if (!stall)
                         state_nxt = (RD_LAT == 0) ? S_ACK : S_WAIT;
            S_WAIT:  if (lat == 2'd1) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, grant, pointer, latency and captured data registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            grant         <= '0;
            ptr           <= '0;
            addr_q        <= '0;
            lat           <= '0;
            bus.int_dat_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && sel_valid) begin
                grant  <= sel_idx;
                addr_q <= bus.int_addr_i[int'(sel_idx)*ADDR_W +: ADDR_W];
            end
            if (issue) lat <= 2'(RD_LAT);
            else if (state == S_WAIT) lat <= lat - 2'd1;
            if (capture) bus.int_dat_o <= bus.mem_dat_i;
            if (state == S_ACK)
                ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Bus reservation window: every bus pulse reloads address and count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold       <= '0;
            bus_addr_q <= '0;
        end else if (bus.bus_req_i) begin
            hold       <= HW'(BUS_HOLD - 1);
            bus_addr_q <= bus.bus_addr_i;
        end else if (hold != '0) begin
            hold <= hold - 1'b1;
        end
    end

    // Port mux: live bus pulse, then held bus address, then internal issue.
    always_comb begin
        mem_addr = '0;
        if (bus.bus_req_i)  mem_addr = bus.bus_addr_i;
        else if (hold != '0) mem_addr = bus_addr_q;
        else if (issue)     mem_addr = addr_q;
    end

    // One-hot ack for the granted requester while in ACK.
    always_comb begin
        ack = '0;
        if (state == S_ACK) ack[grant] = 1'b1;
    end

    assign bus.mem_addr_o = mem_addr;
    assign bus.bus_dat_o  = bus.mem_dat_i;
    assign bus.int_ack_o  = ack;
    assign bus.busy_o     = (state != S_IDLE);

`ifdef TURF_BANK_ARB_STATS_EN
    // Saturating count of stalled ISSUE cycles; clear beats increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr_i)
            stall_cnt_o <= '0;
        else if (state == S_ISSUE && stall && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_turf_bank_arbiter.sv
// tb_turf_bank_arbiter: directed table-driven bench for turf_bank_arbiter
// with a one-cycle-latency bank model returning {26'h0, addr}.
module tb_turf_bank_arbiter;
    import turf_bank_pkg::*;

    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turf_bank_if #(.NREQ(NREQ)) bus ();

    logic [5:0] addr_d;
    always @(posedge clk) addr_d <= bus.mem_addr_o;
    assign bus.mem_dat_i = {26'h0, addr_d};

`ifdef TURF_BANK_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] stall_cnt;
`endif

    turf_bank_arbiter #(.NREQ(NREQ), .RD_LAT(1), .BUS_HOLD(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef TURF_BANK_ARB_STATS_EN
        .stats_clr_i (stats_clr),
        .stall_cnt_o (stall_cnt),
`endif
        .bus         (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [5:0]  a0;
        logic [5:0]  a1;
        int          bus_off;
        logic [5:0]  baddr;
        logic [1:0]  exp_ack;
        int          exp_cyc;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt[8];

    task automatic run_vec(input vec_t v, input int id);
        bit got;
        got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            bus.int_req_i  = v.mask;
            bus.int_addr_i = {v.a1, v.a0};
            bus.bus_req_i  = (n == v.bus_off);
            bus.bus_addr_i = v.baddr;
            #1;
            if (n == 0)
                chk($sformatf("v%0d_idle", id), 32'(bus.busy_o), 32'd0);
            if (v.bus_off >= 0 && n >= v.bus_off && n < v.bus_off + 4)
                chk($sformatf("v%0d_busaddr_c%0d", id, n),
                    32'(bus.mem_addr_o), 32'(v.baddr));
            if (bus.int_ack_o != '0) begin
                got = 1;
                chk($sformatf("v%0d_ack", id), 32'(bus.int_ack_o),
                    32'(v.exp_ack));
                chk($sformatf("v%0d_cyc", id), n, v.exp_cyc);
                chk($sformatf("v%0d_dat", id), bus.int_dat_o, v.exp_dat);
            end
            @(posedge clk);
            #1;
        end
        bus.int_req_i = '0;
        bus.bus_req_i = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL v%0d_timeout actual=none required=ack", id);
        end
        repeat (5) step();
    endtask

    initial begin
        int na;
        int first;
        bus.bus_req_i  = 1'b0;
        bus.bus_addr_i = '0;
        bus.int_req_i  = '0;
        bus.int_addr_i = '0;

        //           mask   a0     a1     boff baddr  ack    cyc dat
        vt[0] = '{2'b01, 6'h05, 6'h00, -1, 6'h00, 2'b01, 3, 32'h05};
        vt[1] = '{2'b01, 6'h11, 6'h00, -1, 6'h00, 2'b01, 3, 32'h11};
        vt[2] = '{2'b10, 6'h00, 6'h3F, -1, 6'h00, 2'b10, 3, 32'h3F};
        vt[3] = '{2'b11, 6'h0A, 6'h0B, -1, 6'h00, 2'b01, 3, 32'h0A};
        vt[4] = '{2'b11, 6'h0C, 6'h0D, -1, 6'h00, 2'b10, 3, 32'h0D};
        vt[5] = '{2'b01, 6'h07, 6'h00,  1, 6'h2A, 2'b01, 7, 32'h07};
        vt[6] = '{2'b10, 6'h00, 6'h21,  2, 6'h3C, 2'b10, 3, 32'h21};
        vt[7] = '{2'b01, 6'h15, 6'h00,  0, 6'h19, 2'b01, 6, 32'h15};

        // Reset state
        repeat (3) step();
        chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        chk("rst_ack", 32'(bus.int_ack_o), 32'd0);
        chk("rst_dat", bus.int_dat_o, 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        chk("bus_dat_pass", bus.bus_dat_o, {26'h0, addr_d});

        // Early drop: pointer is 1, requester 1 drops during WAIT
        na = 0;
        bus.int_addr_i = {6'h02, 6'h01};
        for (int n = 0; n < 20 && na < 2; n++) begin
            bus.int_req_i = (n >= 2) ? 2'b01 : 2'b11;
            #1;
            if (bus.int_ack_o != '0) begin
                if (na == 0) begin
                    chk("drop_ack1", 32'(bus.int_ack_o), 32'b10);
                    chk("drop_cyc1", n, 3);
                    chk("drop_dat1", bus.int_dat_o, 32'h02);
                end else begin
                    chk("drop_ack0", 32'(bus.int_ack_o), 32'b01);
                    chk("drop_cyc0", n, 7);
                    chk("drop_dat0", bus.int_dat_o, 32'h01);
                end
                na++;
            end
            step();
        end
        bus.int_req_i = '0;
        checks++;
        if (na != 2) begin
            failures++;
            $display("FAIL drop_count actual=%0d required=2", na);
        end
        repeat (5) step();

        // Reset mid-WAIT: pointer is 1, reset abandons grant 1
        bus.int_addr_i = {6'h04, 6'h03};
        bus.int_req_i  = 2'b11;
        first = -1;
        for (int n = 0; n < 20 && first < 0; n++) begin
            rst = (n == 2);
            #1;
            if (n == 3) begin
                chk("rmid_ack", 32'(bus.int_ack_o), 32'd0);
                chk("rmid_busy", 32'(bus.busy_o), 32'd0);
                chk("rmid_dat", bus.int_dat_o, 32'd0);
                chk("rmid_addr", 32'(bus.mem_addr_o), 32'd0);
            end
            if (bus.int_ack_o != '0) begin
                first = n;
                chk("rmid_next_ack", 32'(bus.int_ack_o), 32'b01);
                chk("rmid_next_dat", bus.int_dat_o, 32'h03);
            end
            step();
        end
        bus.int_req_i = '0;
        chk("rmid_next_cyc", first, 6);
        repeat (5) step();

        // Round-robin fairness from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.int_addr_i = {6'h0B, 6'h0A};
        bus.int_req_i  = 2'b11;
        na = 0;
        for (int n = 0; n < 40 && na < 6; n++) begin
            #1;
            if (bus.int_ack_o != '0) begin
                chk($sformatf("rr_ack%0d", na), 32'(bus.int_ack_o),
                    (na % 2 == 0) ? 32'b01 : 32'b10);
                chk($sformatf("rr_cyc%0d", na), n, 3 + 4 * na);
                na++;
            end
            step();
        end
        bus.int_req_i = '0;
        chk("rr_count", na, 6);
        repeat (5) step();

`ifdef TURF_BANK_ARB_STATS_EN
        // Three bus pulses hold a pending ISSUE for 12 cycles
        bus.int_addr_i = {6'h00, 6'h09};
        bus.int_req_i  = 2'b01;
        bus.bus_addr_i = 6'h30;
        first = -1;
        for (int n = 0; n < 30 && first < 0; n++) begin
            bus.bus_req_i = (n == 1 || n == 5 || n == 9);
            #1;
            if (bus.int_ack_o != '0) begin
                first = n;
                chk("st_dat", bus.int_dat_o, 32'h09);
            end
            step();
        end
        bus.int_req_i = '0;
        bus.bus_req_i = 1'b0;
        chk("st_cyc", first, 15);
        chk("st_cnt", 32'(stall_cnt), 32'd12);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("st_clr", 32'(stall_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/turf_bank_arbiter.md
Name: turf_bank_arbiter

Overview:
- Shares the muxed bank read port (6-bit address out, 32-bit data in) between the TURFIO register bus and up to NREQ internal requesters, e.g. scaler snapshot engine and event-header prefetch.
- The TURFIO bus always has absolute priority and sees zero added latency.
- Internal requesters are served round-robin around bus activity.
- Sits between the TURF register interface and the scaler/event bank muxes.

Parameters:
- NREQ, 2, number of internal requesters (1..8).
- RD_LAT, 1, cycles from mem_addr_o to valid mem_dat_i (0..3).
- BUS_HOLD, 4, cycles the port stays reserved for the bus after bus_req_i (covers the byte-serial read-out).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active high.
- bus_req_i  in  1  single-cycle pulse: TURFIO read targeting this bank.
- bus_addr_i  in  6  TURFIO bank address.
- mem_addr_o  out  6  address to bank mux.
- mem_dat_i  in  32  bank read data.
- bus_dat_o  out  32  mem_dat_i passthrough to register interface.
- int_req_i  in  NREQ  per-requester read request, level.
- int_addr_i  in  6*NREQ  packed requester addresses; requester k at [6k+5:6k].
- int_ack_o  out  NREQ  one-cycle ack, data valid same cycle.
- int_dat_o  out  32  captured read data for acked requester.
- busy_o  out  1  internal transaction in progress.

Behaviour:
- Clock and reset: one clock clk_i; reset is synchronous and active-high on rst_i.
- Reset values: mem_addr_o=0, int_ack_o=0, int_dat_o=0, busy_o=0, RR pointer=0, hold counter=0, FSM=IDLE.
- Reset mid-transaction: abandons the transaction without an ack.
- Bus path:
  - When bus_req_i=1, mem_addr_o=bus_addr_i combinationally in that same cycle.
  - bus_addr_i is registered and held on mem_addr_o for the next BUS_HOLD-1 cycles.
  - The hold counter loads BUS_HOLD-1.
  - A new bus_req_i during the hold window reloads the counter and the address.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any int_req_i is high, select the first requester at or after the RR pointer (wrapping modulo NREQ).
  - Latch its index and address, then go to ISSUE.
- ISSUE:
  - If bus_req_i=1 or hold counter≠0, stall in ISSUE (port busy).
  - Otherwise drive the latched address on mem_addr_o for one cycle.
  - Go to WAIT with latency counter=RD_LAT; if RD_LAT=0, go directly to ACK and capture this cycle.
- WAIT: decrement the counter each cycle; in the cycle the counter reaches 0, capture mem_dat_i into int_dat_o and go to ACK.
- Bus pulses during WAIT or ACK do not affect the internal capture. The memory is pipelined, so the read was already issued.
- ACK:
  - Pulse int_ack_o[grant]=1 for one cycle.
  - Set RR pointer = grant+1, wrapping to 0 at NREQ.
  - Return to IDLE.
  - IDLE may grant again on the next cycle, so minimum internal throughput is one read per RD_LAT+3 cycles.
- Grant is fixed once latched in IDLE. Deasserting int_req_i before ack still completes the read; the ack pulses and is ignored.
- Requesters must hold int_addr_i stable only in the IDLE cycle in which they are granted.
- busy_o=1 in ISSUE, WAIT and ACK.
- bus_dat_o=mem_dat_i always. Bus-side timing belongs to the register interface.
- Simultaneous bus_req_i and internal ISSUE: the bus wins and the internal request stalls. No abort or retry is needed.

Optional Feature:
- Macro: TURF_BANK_ARB_STATS_EN.
- When defined, adds ports stats_clr_i (in, 1) and stall_cnt_o (out, 16).
  - stall_cnt_o is a saturating count (stops at 16'hFFFF) of cycles spent stalled in ISSUE.
  - It is cleared by rst_i or stats_clr_i; a clear wins over an increment in the same cycle.
- When not defined, these ports and the counter are absent, and the arbitration behaviour is identical.

Decomposition:
- Shared package turf_bank_pkg:
  - FSM state encoding (IDLE/ISSUE/WAIT/ACK, 2 bits).
  - Bank address width constant (6).
  - Data width constant (32).
- One natural sub-module, turf_rr_select: combinational round-robin first-one-from-pointer selector producing the grant index and a valid flag.

Test Plan:
- Single requester, RD_LAT=1, no bus traffic:
  - Stimulus: int_req_i[0]=1, addr 6'h05, memory model returns {26'h0,addr} after RD_LAT.
  - Required: ack exactly 3 cycles after the request is seen (ISSUE→WAIT→ACK), with int_dat_o=32'h5.
- Bus preemption:
  - Stimulus: bus_req_i pulse with bus_addr_i=6'h2A in the same cycle FSM enters ISSUE.
  - Required: mem_addr_o=6'h2A for 4 cycles; internal address issued on cycle 5; ack delayed by exactly 4 cycles; int_dat_o correct.
- Round-robin fairness:
  - Stimulus: NREQ=2, both requests held high for 6 transactions.
  - Required: ack order 0,1,0,1,0,1; no back-to-back grant to the same index.
- Early drop:
  - Stimulus: int_req_i[1] deasserted during WAIT.
  - Required: int_ack_o[1] still pulses once; the next grant goes to requester 0 if pending.
- Reset mid-WAIT:
  - Stimulus: rst_i=1 for 1 cycle.
  - Required: no ack; all outputs 0; next request served from RR pointer 0.
- Stats (with TURF_BANK_ARB_STATS_EN):
  - Stimulus: 3 bus pulses, each spaced 4 cycles apart, overlapping a pending ISSUE.
  - Required: stall_cnt_o=12; stats_clr_i asserted → stall_cnt_o=0 on the next cycle.
